// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing parameter sets and helpers
// Porch/border sizes for common modes plus the derived total/active-start math.
package vga_timing_pkg;

  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 40;
  localparam int VGA640_H_LEFT   = 8;
  localparam int VGA640_H_VALID  = 640;
  localparam int VGA640_H_RIGHT  = 8;
  localparam int VGA640_H_FRONT  = 8;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 25;
  localparam int VGA640_V_TOP    = 8;
  localparam int VGA640_V_VALID  = 480;
  localparam int VGA640_V_BOTTOM = 8;
  localparam int VGA640_V_FRONT  = 2;

  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BACK   = 88;
  localparam int SVGA800_H_LEFT   = 0;
  localparam int SVGA800_H_VALID  = 800;
  localparam int SVGA800_H_RIGHT  = 0;
  localparam int SVGA800_H_FRONT  = 40;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BACK   = 23;
  localparam int SVGA800_V_TOP    = 0;
  localparam int SVGA800_V_VALID  = 600;
  localparam int SVGA800_V_BOTTOM = 0;
  localparam int SVGA800_V_FRONT  = 1;

  function automatic int axis_total(input int sync, input int back, input int lead,
                                    input int valid, input int trail, input int front);
    return sync + back + lead + valid + trail + front;
  endfunction

  // First active coordinate: everything before the visible area on this axis.
  function automatic int active_start(input int sync, input int back, input int lead);
    return sync + back + lead;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - wrapping position counter for one raster axis
// wrap flags the stepping cycle at TOTAL-1; clear forces the count back to 0.
module vga_axis_cnt #(
  parameter int TOTAL = 800,
  parameter int W     = 11
) (
  input  logic         vga_clk,
  input  logic         sys_rst_n,
  input  logic         step,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] r_count;

  assign wrap  = step && (r_count == W'(TOTAL - 1));
  assign count = r_count;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_count <= '0;
    end else if (clear || wrap) begin
      r_count <= '0;
    end else if (step) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
// Drives a pipelined pixel source ahead of the beam and registers sync/de/rgb together.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int H_LEFT    = VGA640_H_LEFT,
  parameter int H_VALID   = VGA640_H_VALID,
  parameter int H_RIGHT   = VGA640_H_RIGHT,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter int V_TOP     = VGA640_V_TOP,
  parameter int V_VALID   = VGA640_V_VALID,
  parameter int V_BOTTOM  = VGA640_V_BOTTOM,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int CNT_W     = 11,
  parameter int DATA_W    = 24,
  parameter int REQ_LEAD  = 1,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter bit BORDER_EN = 1'b0
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] border_rgb,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start,
  output logic              line_start
);

  localparam int A_H     = active_start(H_SYNC, H_BACK, H_LEFT);
  localparam int A_V     = active_start(V_SYNC, V_BACK, V_TOP);
  localparam int H_TOTAL = axis_total(H_SYNC, H_BACK, H_LEFT, H_VALID, H_RIGHT, H_FRONT);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BACK, V_TOP, V_VALID, V_BOTTOM, V_FRONT);
  localparam int REQ_H0  = A_H - REQ_LEAD;

  if (REQ_LEAD < 1 || REQ_LEAD > 7 || REQ_LEAD > A_H ||
      H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_param_err
    $error("vga_timing_gen: illegal REQ_LEAD or totals exceed counter range");
  end

  logic              r_run;
  logic [CNT_W-1:0]  w_cnt_h;
  logic [CNT_W-1:0]  w_cnt_v;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_clear;
  logic [31:0]       w_h;
  logic [31:0]       w_v;
  logic              w_act_line;
  logic              w_active;
  logic              w_border;
  logic [DATA_W-1:0] w_rgb_nxt;

  logic              r_hsync;
  logic              r_vsync;
  logic              r_de;
  logic [DATA_W-1:0] r_rgb;
  logic              r_frame_start;
  logic              r_line_start;

  assign w_clear = !r_run;

  vga_axis_cnt #(.TOTAL(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .step      (r_run),
    .clear     (w_clear),
    .count     (w_cnt_h),
    .wrap      (w_h_wrap)
  );

  vga_axis_cnt #(.TOTAL(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .step      (w_h_wrap),
    .clear     (w_clear),
    .count     (w_cnt_v),
    .wrap      (w_v_wrap)
  );

  // Stopping is only honoured at the last pixel of a frame so frames are never cut short.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_run <= 1'b0;
    end else if (!r_run) begin
      r_run <= en;
    end else if (w_h_wrap && w_v_wrap && !en) begin
      r_run <= 1'b0;
    end
  end

  assign w_h = 32'(w_cnt_h);
  assign w_v = 32'(w_cnt_v);

  assign w_act_line = (w_v >= A_V) && (w_v < A_V + V_VALID);
  assign w_active   = r_run && w_act_line && (w_h >= A_H) && (w_h < A_H + H_VALID);
  assign w_border   = r_run && !w_active &&
                      (w_h >= H_SYNC + H_BACK) && (w_h < H_TOTAL - H_FRONT) &&
                      (w_v >= V_SYNC + V_BACK) && (w_v < V_TOTAL - V_FRONT);

  // Requests run REQ_LEAD pixels ahead so the source's data lands on the active pixel.
  assign pix_req = r_run && w_act_line && (w_h >= REQ_H0) && (w_h < REQ_H0 + H_VALID);
  assign pix_x   = pix_req ? CNT_W'(w_h - 32'(REQ_H0)) : '1;
  assign pix_y   = pix_req ? CNT_W'(w_v - 32'(A_V)) : '1;

  always_comb begin
    w_rgb_nxt = '0;
    if (w_active) begin
      w_rgb_nxt = pix_data;
    end else if (BORDER_EN && w_border) begin
      w_rgb_nxt = border_rgb;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hsync       <= !HS_POL;
      r_vsync       <= !VS_POL;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_hsync       <= (r_run && (w_h < H_SYNC)) ? HS_POL : !HS_POL;
      r_vsync       <= (r_run && (w_v < V_SYNC)) ? VS_POL : !VS_POL;
      r_de          <= w_active;
      r_rgb         <= w_rgb_nxt;
      r_frame_start <= r_run && (w_h == 0) && (w_v == 0);
      r_line_start  <= r_run && (w_h == 0);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign rgb         = r_rgb;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench for vga_timing_gen against a raster model
// Two small-mode instances; the model tracks linear raster position per instance.
module tb_vga_timing_gen;

  localparam int NCYC = 12000;

  localparam int A_HS = 4, A_HB = 3, A_HL = 2, A_HV = 8, A_HR = 2, A_HF = 3;
  localparam int A_VS = 2, A_VB = 2, A_VT = 1, A_VV = 5, A_VBT = 1, A_VF = 2;
  localparam int A_LEAD = 3;
  localparam int B_HS = 2, B_HB = 1, B_HL = 1, B_HV = 4, B_HR = 1, B_HF = 1;
  localparam int B_VS = 1, B_VB = 1, B_VT = 0, B_VV = 3, B_VBT = 0, B_VF = 1;
  localparam int B_LEAD = 2;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic        en_a, en_b;
  logic [23:0] border_rgb, pix_a, pix_b;
  logic        a_req, a_hs, a_vs, a_de, a_fs, a_ls;
  logic        b_req, b_hs, b_vs, b_de, b_fs, b_ls;
  logic [10:0] a_x, a_y, b_x, b_y;
  logic [23:0] a_rgb, b_rgb;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_SYNC(A_HS), .H_BACK(A_HB), .H_LEFT(A_HL), .H_VALID(A_HV), .H_RIGHT(A_HR), .H_FRONT(A_HF),
    .V_SYNC(A_VS), .V_BACK(A_VB), .V_TOP(A_VT), .V_VALID(A_VV), .V_BOTTOM(A_VBT), .V_FRONT(A_VF),
    .CNT_W(11), .DATA_W(24), .REQ_LEAD(A_LEAD), .HS_POL(1'b1), .VS_POL(1'b1), .BORDER_EN(1'b1)
  ) u_dut_a (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .en(en_a), .border_rgb(border_rgb),
    .pix_data(pix_a), .pix_req(a_req), .pix_x(a_x), .pix_y(a_y), .hsync(a_hs),
    .vsync(a_vs), .de(a_de), .rgb(a_rgb), .frame_start(a_fs), .line_start(a_ls)
  );

  vga_timing_gen #(
    .H_SYNC(B_HS), .H_BACK(B_HB), .H_LEFT(B_HL), .H_VALID(B_HV), .H_RIGHT(B_HR), .H_FRONT(B_HF),
    .V_SYNC(B_VS), .V_BACK(B_VB), .V_TOP(B_VT), .V_VALID(B_VV), .V_BOTTOM(B_VBT), .V_FRONT(B_VF),
    .CNT_W(11), .DATA_W(24), .REQ_LEAD(B_LEAD), .HS_POL(1'b0), .VS_POL(1'b0), .BORDER_EN(1'b0)
  ) u_dut_b (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .en(en_b), .border_rgb(border_rgb),
    .pix_data(pix_b), .pix_req(b_req), .pix_x(b_x), .pix_y(b_y), .hsync(b_hs),
    .vsync(b_vs), .de(b_de), .rgb(b_rgb), .frame_start(b_fs), .line_start(b_ls)
  );

  logic [4:0]  o_flags [2];
  logic [23:0] o_rgb   [2];
  logic [22:0] o_req   [2];
  assign o_flags[0] = {a_hs, a_vs, a_de, a_fs, a_ls};
  assign o_flags[1] = {b_hs, b_vs, b_de, b_fs, b_ls};
  assign o_rgb[0]   = a_rgb;
  assign o_rgb[1]   = b_rgb;
  assign o_req[0]   = {a_req, a_x, a_y};
  assign o_req[1]   = {b_req, b_x, b_y};

  int hp [2][6];
  int vp [2][6];
  int lead [2];
  bit bord [2];
  bit hpol [2];
  bit vpol [2];
  logic [23:0] salt [2];

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames [2];

  bit          m_run [2];
  int          m_pos [2];
  logic [4:0]  e_flags [2];
  logic [23:0] e_rgb [2];
  logic [23:0] src_a [$];
  logic [23:0] src_b [$];
  int          rst_hold;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int h_total(input int k);
    return hp[k][0] + hp[k][1] + hp[k][2] + hp[k][3] + hp[k][4] + hp[k][5];
  endfunction

  function automatic int v_total(input int k);
    return vp[k][0] + vp[k][1] + vp[k][2] + vp[k][3] + vp[k][4] + vp[k][5];
  endfunction

  function automatic logic [23:0] pixfn(input int k, input int x, input int y);
    return {12'(y), 12'(x)} ^ salt[k];
  endfunction

  // Expected registered outputs one cycle after raster position pos (h = pos mod width).
  task automatic model_reg(input int k, input bit run, input int pos, input logic [23:0] brgb,
                           output logic [4:0] flags, output logic [23:0] col);
    int h, v, ah, av;
    bit act, brd;
    h   = pos % h_total(k);
    v   = pos / h_total(k);
    ah  = hp[k][0] + hp[k][1] + hp[k][2];
    av  = vp[k][0] + vp[k][1] + vp[k][2];
    act = run && h >= ah && h < ah + hp[k][3] && v >= av && v < av + vp[k][3];
    brd = run && !act && h >= hp[k][0] + hp[k][1] && h < h_total(k) - hp[k][5]
                      && v >= vp[k][0] + vp[k][1] && v < v_total(k) - vp[k][5];
    flags[4] = (run && h < hp[k][0]) ? hpol[k] : !hpol[k];
    flags[3] = (run && v < vp[k][0]) ? vpol[k] : !vpol[k];
    flags[2] = act;
    flags[1] = run && h == 0 && v == 0;
    flags[0] = run && h == 0;
    col = act ? pixfn(k, h - ah, v - av) : (bord[k] && brd) ? brgb : 24'h0;
  endtask

  task automatic model_comb(input int k, input bit run, input int pos, output logic [22:0] rv);
    int h, v, ah, av;
    bit req;
    h   = pos % h_total(k);
    v   = pos / h_total(k);
    ah  = hp[k][0] + hp[k][1] + hp[k][2];
    av  = vp[k][0] + vp[k][1] + vp[k][2];
    req = run && v >= av && v < av + vp[k][3] && h >= ah - lead[k] && h < ah + hp[k][3] - lead[k];
    rv  = req ? {1'b1, 11'(h - (ah - lead[k])), 11'(v - av)} : {1'b0, 22'h3fffff};
  endtask

  initial begin
    logic [22:0] exp_req;
    logic [4:0]  rst_flags;
    logic [23:0] rst_rgb;
    bit          en_k;
    bit          last;

    hp[0] = '{A_HS, A_HB, A_HL, A_HV, A_HR, A_HF};
    vp[0] = '{A_VS, A_VB, A_VT, A_VV, A_VBT, A_VF};
    hp[1] = '{B_HS, B_HB, B_HL, B_HV, B_HR, B_HF};
    vp[1] = '{B_VS, B_VB, B_VT, B_VV, B_VBT, B_VF};
    lead = '{A_LEAD, B_LEAD};
    bord = '{1'b1, 1'b0};
    hpol = '{1'b1, 1'b0};
    vpol = '{1'b1, 1'b0};
    salt[0] = 24'($urandom);
    salt[1] = 24'($urandom);

    sys_rst_n  = 1'b0;
    en_a       = 1'b1;
    en_b       = 1'b1;
    border_rgb = 24'hff0000;
    pix_a      = '0;
    pix_b      = '0;
    rst_hold   = 2;
    for (int i = 0; i < A_LEAD; i++) src_a.push_back(24'h0);
    for (int i = 0; i < B_LEAD; i++) src_b.push_back(24'h0);
    for (int k = 0; k < 2; k++) begin
      m_run[k]    = 1'b0;
      m_pos[k]    = 0;
      n_frames[k] = 0;
      model_reg(k, 1'b0, 0, 24'h0, e_flags[k], e_rgb[k]);
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge vga_clk);
      for (int k = 0; k < 2; k++) begin
        model_comb(k, m_run[k], m_pos[k], exp_req);
        check_value(k == 0 ? "a_flags" : "b_flags", 64'(o_flags[k]), 64'(e_flags[k]));
        check_value(k == 0 ? "a_rgb" : "b_rgb", 64'(o_rgb[k]), 64'(e_rgb[k]));
        check_value(k == 0 ? "a_req" : "b_req", 64'(o_req[k]), 64'(exp_req));
      end

      if (!sys_rst_n) begin
        if (rst_hold == 0) sys_rst_n = 1'b1;
        else rst_hold--;
      end else if (cyc == 2003 || $urandom_range(0, 2499) == 0) begin
        sys_rst_n = 1'b0;
        rst_hold  = $urandom_range(0, 2);
        #1;
        for (int k = 0; k < 2; k++) begin
          model_reg(k, 1'b0, 0, 24'h0, rst_flags, rst_rgb);
          check_value("async_rst_flags", 64'(o_flags[k]), 64'(rst_flags));
          check_value("async_rst_rgb", 64'(o_rgb[k]), 64'(rst_rgb));
          check_value("async_rst_req", 64'(o_req[k]), 64'({1'b0, 22'h3fffff}));
        end
      end

      if ($urandom_range(0, 149) == 0) en_a = !en_a;
      if ($urandom_range(0, 99) == 0)  en_b = !en_b;
      border_rgb = 24'($urandom);

      src_a.push_back(a_req ? pixfn(0, int'(a_x), int'(a_y)) : 24'($urandom));
      pix_a = src_a.pop_front();
      src_b.push_back(b_req ? pixfn(1, int'(b_x), int'(b_y)) : 24'($urandom));
      pix_b = src_b.pop_front();

      for (int k = 0; k < 2; k++) begin
        en_k = (k == 0) ? en_a : en_b;
        if (!sys_rst_n) begin
          m_run[k] = 1'b0;
          m_pos[k] = 0;
          model_reg(k, 1'b0, 0, border_rgb, e_flags[k], e_rgb[k]);
        end else begin
          model_reg(k, m_run[k], m_pos[k], border_rgb, e_flags[k], e_rgb[k]);
          if (e_flags[k][1]) n_frames[k]++;
          if (!m_run[k]) begin
            m_run[k] = en_k;
          end else begin
            last     = (m_pos[k] == h_total(k) * v_total(k) - 1);
            m_pos[k] = (m_pos[k] + 1) % (h_total(k) * v_total(k));
            if (last && !en_k) m_run[k] = 1'b0;
          end
        end
      end
    end

    check_value("frames_seen_a", 64'(n_frames[0] >= 10), 64'(1));
    check_value("frames_seen_b", 64'(n_frames[1] >= 40), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with a pixel-fetch request interface. It supersedes the fixed-640x480 resistor-network controller. Adds: resolution and porch sizes as parameters, programmable sync polarity, a configurable request lead for pipelined pixel sources, border colour fill, frame-boundary enable/disable, and registered glitch-free outputs. It sits between the pixel source (ROM, frame buffer or pattern generator) and the DAC/resistor network.

## Interface
- H_SYNC, 96: hsync width, pixels
- H_BACK, 40: back porch
- H_LEFT, 8: left border
- H_VALID, 640: active pixels
- H_RIGHT, 8: right border
- H_FRONT, 8: front porch
- V_SYNC 2, V_BACK 25, V_TOP 8, V_VALID 480, V_BOTTOM 8, V_FRONT 2: vertical equivalents, in lines
- CNT_W, 11: counter and coordinate width
- DATA_W, 24: pixel width
- REQ_LEAD, 1: pixel source pipeline depth, 1..7
- HS_POL, 1 / VS_POL, 1: active sync level
- BORDER_EN, 0: fill border region with border_rgb

Ports:
- vga_clk  in  1  pixel clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run request
- border_rgb  in  DATA_W  border colour
- pix_data  in  DATA_W  pixel from source
- pix_req  out  1  pixel request (combinational from counters)
- pix_x, pix_y  out  CNT_W  requested coordinate; all ones when pix_req=0
- hsync, vsync  out  1  registered syncs
- de  out  1  registered active-video flag
- rgb  out  DATA_W  registered colour
- frame_start, line_start  out  1  registered one-cycle pulses

## Operation
- Derived values:
  - A_H = H_SYNC+H_BACK+H_LEFT
  - H_TOTAL = sum of all H parameters
  - A_V, V_TOTAL likewise
- Elaboration error if REQ_LEAD > A_H, REQ_LEAD = 0, or H_TOTAL/V_TOTAL exceeds 2^CNT_W.
- cnt_h counts 0..H_TOTAL-1. cnt_v increments when cnt_h wraps, and wraps to 0 at V_TOTAL-1.
- run flag (reset 0):
  - Sets in any cycle where run=0 and en=1. Counting starts the next cycle.
  - Clears at the frame-end cycle (cnt_h=H_TOTAL-1, cnt_v=V_TOTAL-1) if en=0.
  - While run=0, counters hold at 0 and all outputs take their reset values.
- Sync regions:
  - hsync region: cnt_h < H_SYNC.
  - vsync region: cnt_v < V_SYNC.
  - Output level is the POL parameter inside the region and its inverse outside.
- Active region: cnt_h in [A_H, A_H+H_VALID) and cnt_v in [A_V, A_V+V_VALID).
- Request window: cnt_h in [A_H-REQ_LEAD, A_H+H_VALID-REQ_LEAD) on active lines, with run=1.
  - pix_x = cnt_h-(A_H-REQ_LEAD).
  - pix_y = cnt_v-A_V.
- Source contract: pix_data carries pixel (pix_x, pix_y) exactly REQ_LEAD cycles after the request cycle.
- Border region: cnt_h in [H_SYNC+H_BACK, H_TOTAL-H_FRONT) and cnt_v in [V_SYNC+V_BACK, V_TOTAL-V_FRONT), minus the active region.
- Colour selection: rgb = pix_data when active; else border_rgb if BORDER_EN and in the border region; else 0.
- Pulses: line_start when cnt_h=0; frame_start when cnt_h=0 and cnt_v=0; both only while run=1.

## Timing
- Reset values:
  - hsync=!HS_POL, vsync=!VS_POL
  - de=0, rgb=0, frame_start=0, line_start=0
  - pix_req=0, pix_x/pix_y all ones
- All registered outputs reflect the counter state of the previous cycle (1-cycle latency). hsync, vsync, de and rgb stay mutually aligned.
- Pixel latency: a request at counter cycle c yields de=1 with that pixel on rgb at cycle c+REQ_LEAD+1.
- Simultaneous wrap of cnt_h and cnt_v: both go to 0 in the same cycle, and frame_start follows one cycle later.
- en toggling mid-frame: no effect until the frame-end cycle, so frames are never truncated.
- Reset mid-operation: all outputs return to reset values asynchronously. After release, counting restarts from (0,0) once en=1.
- border_rgb is sampled every cycle; there is no synchronisation.

## Structure
- Shared package vga_timing_pkg holds:
  - 640x480@60 and 800x600@60 parameter sets as localparams
  - total/active-start helper functions
- Sub-module vga_axis_cnt:
  - Parameters TOTAL, W; inputs step, clear.
  - Outputs count and wrap.
  - Instantiated twice: horizontal steps every run cycle; vertical steps on the horizontal wrap.

## Test plan
- Defaults, en=1 from reset:
  - hsync high for 96 cycles, period 800.
  - vsync high for 2 lines (1600 cycles), period 525 lines.
  - frame_start every 420000 cycles.
- REQ_LEAD=3, source = 3-stage pipeline returning {pix_y, pix_x}:
  - First pix_req at cnt_h=141, cnt_v=35 with pix_x=0, pix_y=0.
  - de first high 4 cycles later with rgb=0.
  - 640 de cycles per line, 480 lines per frame, no mismatches.
- BORDER_EN=1, border_rgb=0xFF0000:
  - rgb=0xFF0000 on active lines for cnt_h 136..143 and 784..791.
  - rgb=0xFF0000 on lines 27..34 and 515..522 for cnt_h 136..791.
  - rgb=0 elsewhere outside active.
- en dropped at cnt_v=100:
  - Frame finishes through (799,524); counters then hold at 0 with outputs at reset values.
  - en=1 again: frame_start one cycle after counting resumes.
- sys_rst_n pulsed low at cnt_h=400, cnt_v=200:
  - Immediate reset values.
  - Restart from (0,0); line_start pulses once.
- HS_POL=0, VS_POL=0, tiny timing (H: 2,1,1,4,1,1; V: 1,1,0,3,0,1):
  - Inverted syncs.
  - Wrap at H_TOTAL=10, V_TOTAL=6.
  - 4 de cycles per active line.
